hazard_scoreboard_unit: RTL
===========================

Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard/forwarding controller for the RV32I 5-stage pipeline.
- Internally tracks destination registers in flight through EX, MEM and WB, so it needs no per-stage RD inputs from the datapath.
- Scoreboards one outstanding long-latency operation (multi-cycle MUL/DIV) and resolves RAW, load-use, WAW and structural hazards.
- Generates per-read-port forward selects for ID and a single stall to the front end, for a parametrised number of read ports.

Parameters:
- NUM_RD_PORTS, 2, number of ID source-operand ports needing forward/stall resolution.
- REG_ADDR_W, ADDRESS_PORT_WIDTH (5), register address width; the register count is 2**REG_ADDR_W.
- MAX_LONG_LAT, 40, cycle limit for an outstanding long op before the error flag sets.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  NUM_RD_PORTS*REG_ADDR_W  source addresses; port p at bits [p*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_RD_PORTS  port p actually reads its source
- id_rd  in  REG_ADDR_W  destination
- id_regwrite  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- id_is_long  in  1  instruction issues to the long-latency unit
- flush  in  1  kill the ID instruction and the EX slot (branch redirect)
- long_wb_valid  in  1  long unit writes back this cycle
- long_wb_rd  in  REG_ADDR_W  long-unit destination
- stall  out  1  hold PC/IF/ID; the block inserts a bubble into EX
- stall_cause  out  3  {structural, waw_or_long_raw, load_use}
- fwd_sel  out  NUM_RD_PORTS*3  per port: 0 regfile, 1 EX result, 2 MEM result, 3 WB result, 4 long wb data
- long_busy  out  1  long op outstanding
- err  out  1  sticky: timeout or unexpected long writeback

Behaviour:
- Reset (async, rst_n=0):
  - EX/MEM/WB slots invalid; busy_vec cleared; long_busy=0; latency counter=0; err=0.
  - stall=0, stall_cause=0, fwd_sel=0, since these are combinational from cleared state and inputs.
  - Reset mid-operation discards every in-flight tag; a later long_wb_valid sets err.
- Slot state:
  - Each slot holds {valid, rd, regwrite, is_load}.
  - Every cycle EX->MEM->WB shift and WB retires.
  - EX loads the ID fields when id_valid & !stall & !flush; otherwise it loads a bubble (valid=0).
  - A long op enters EX with regwrite forced to 0, because its write is tracked by the scoreboard instead.
- Slot match on port p: valid & regwrite & rd!=0 & rd==id_rs[p] & id_rs_used[p].
- Forward priority, youngest first: EX(1) > MEM(2) > WB(3) > long_wb_valid & long_wb_rd==rs(4) > regfile(0).
  - rs==0 always gives 0.
- Stall, combinational, only when id_valid & !flush:
  - load_use: any used port matches an EX slot with is_load.
  - waw_or_long_raw:
    - a used port's rs is set in busy_vec and not completing this cycle via long_wb; or
    - id_regwrite & id_rd!=0 & busy_vec[id_rd] set and not completing this cycle.
  - structural: id_is_long & long_busy & !(long_wb_valid).
  - stall = OR of the three causes. When stalled, fwd_sel still reflects the current match.
- Scoreboard:
  - Issue of a long op (id_valid & id_is_long & !stall & !flush) sets busy_vec[id_rd] when id_rd!=0 and sets long_busy.
  - long_wb_valid with busy_vec[long_wb_rd] set clears the bit and long_busy.
  - Same-cycle writeback and new long issue: the clear applies first, then the set, so both take effect.
  - long_wb_valid for a non-busy register, or while long_busy=0: ignored, err<=1.
- Latency counter:
  - Resets to 0 on issue and increments while long_busy.
  - Reaching MAX_LONG_LAT sets err, which is sticky until reset. The counter saturates.
- Flush:
  - Invalidates the EX slot at the next edge and blocks the current ID issue.
  - MEM and WB are unaffected, and so is an already-issued long op.

Test Plan:
- Reset mid-flight: assert rst_n=0 after issuing a DIV to x5 -> long_busy=0, fwd_sel=0, stall=0 immediately; a subsequent long_wb_valid rd=5 -> err=1.
- Back-to-back ALU: ADD x3 then SUB x4,x3,x3 -> fwd_sel port0=port1=1, stall=0; one cycle later an independent instr then use of x3 -> fwd_sel=2; two later -> 3.
- Load-use: LW x7 then ADD x8,x7,x1 -> stall=1, stall_cause=3'b001 for exactly 1 cycle, then fwd_sel port0=2 with stall=0.
- Long RAW: DIV x9 issued, ADD x10,x9,x0 follows -> stall with cause 3'b010 until the cycle long_wb_valid rd=9, when stall=0 and fwd_sel port0=4; a second DIV during busy -> cause 3'b100.
- x0 and flush:
  - LW x0 followed by use of x0 -> no stall, fwd_sel=0.
  - flush in the same cycle as a load-use condition -> stall=0 and the EX slot is a bubble the next cycle.
- Timeout: DIV issued, no writeback for MAX_LONG_LAT=40 cycles -> err=1 at cycle 40 and remains 1 after writeback.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline. It tracks its own EX/MEM/WB
// destination tags and scoreboards one outstanding long-latency (MUL/DIV) operation.
module hazard_scoreboard_unit #(
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int MAX_LONG_LAT = 40
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_RD_PORTS-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]              id_rd,
    input  logic                               id_regwrite,
    input  logic                               id_is_load,
    input  logic                               id_is_long,
    input  logic                               flush,
    input  logic                               long_wb_valid,
    input  logic [REG_ADDR_W-1:0]              long_wb_rd,
    output logic                               stall,
    output logic [2:0]                         stall_cause,
    output logic [NUM_RD_PORTS*3-1:0]          fwd_sel,
    output logic                               long_busy,
    output logic                               err
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CNT_W    = $clog2(MAX_LONG_LAT + 1);
    localparam logic [CNT_W-1:0]      LAT_MAX = CNT_W'(MAX_LONG_LAT);
    localparam logic [REG_ADDR_W-1:0] X0      = {REG_ADDR_W{1'b0}};

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  is_load;
    } slot_t;

    slot_t                 ex_r, mem_r, wb_r;
    logic [NUM_REGS-1:0]   busy_vec_r;
    logic                  long_busy_r;
    logic [CNT_W-1:0]      lat_cnt_r;
    logic                  err_r;

    logic [REG_ADDR_W-1:0] rs_s [NUM_RD_PORTS];
    logic                  load_use_s, waw_s, struct_s, stall_s;
    logic [NUM_RD_PORTS*3-1:0] fwd_sel_s;
    logic                  issue_s, long_issue_s, wb_ok_s, lat_hit_s;
    logic [NUM_REGS-1:0]   clr_mask_s, set_mask_s;
    slot_t                 ex_next_s;

    function automatic logic slot_hit(input slot_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid & s.regwrite & (s.rd != X0) & (s.rd == rs);
    endfunction

    // Unpack the source-address bus into one address per read port
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rs_s[p] = id_rs[p*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    // Forward selection (youngest producer wins) and stall-cause detection
    always_comb begin
        load_use_s = 1'b0;
        waw_s      = 1'b0;
        fwd_sel_s  = {(NUM_RD_PORTS*3){1'b0}};
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (id_rs_used[p] && (rs_s[p] != X0)) begin
                if (slot_hit(ex_r, rs_s[p])) begin
                    fwd_sel_s[p*3 +: 3] = 3'd1;
                end else if (slot_hit(mem_r, rs_s[p])) begin
                    fwd_sel_s[p*3 +: 3] = 3'd2;
                end else if (slot_hit(wb_r, rs_s[p])) begin
                    fwd_sel_s[p*3 +: 3] = 3'd3;
                end else if (long_wb_valid && (long_wb_rd == rs_s[p])) begin
                    fwd_sel_s[p*3 +: 3] = 3'd4;
                end else begin
                    fwd_sel_s[p*3 +: 3] = 3'd0;
                end
                if (slot_hit(ex_r, rs_s[p]) && ex_r.is_load) begin
                    load_use_s = 1'b1;
                end else begin
                    load_use_s = load_use_s;
                end
                // A long result landing this cycle is forwarded, so it no longer blocks
                if (busy_vec_r[rs_s[p]] && !(long_wb_valid && (long_wb_rd == rs_s[p]))) begin
                    waw_s = 1'b1;
                end else begin
                    waw_s = waw_s;
                end
            end else begin
                fwd_sel_s[p*3 +: 3] = 3'd0;
            end
        end
        if (id_regwrite && (id_rd != X0) && busy_vec_r[id_rd] &&
            !(long_wb_valid && (long_wb_rd == id_rd))) begin
            waw_s = 1'b1;
        end else begin
            waw_s = waw_s;
        end
        struct_s = id_is_long & long_busy_r & ~long_wb_valid;
        if (!(id_valid && !flush)) begin
            load_use_s = 1'b0;
            waw_s      = 1'b0;
            struct_s   = 1'b0;
        end else begin
            struct_s   = struct_s;
        end
        stall_s = load_use_s | waw_s | struct_s;
    end

    assign issue_s      = id_valid & ~stall_s & ~flush;
    assign long_issue_s = issue_s & id_is_long;
    assign wb_ok_s      = long_wb_valid & long_busy_r & busy_vec_r[long_wb_rd];
    assign clr_mask_s   = {{(NUM_REGS-1){1'b0}}, wb_ok_s} << long_wb_rd;
    assign set_mask_s   = {{(NUM_REGS-1){1'b0}}, (long_issue_s & (id_rd != X0))} << id_rd;
    assign lat_hit_s    = ~long_issue_s & long_busy_r & (lat_cnt_r == (LAT_MAX - CNT_W'(1)));

    // Next EX contents; long ops drop regwrite because the scoreboard owns their write
    always_comb begin
        if (issue_s) begin
            ex_next_s.valid    = 1'b1;
            ex_next_s.rd       = id_rd;
            ex_next_s.regwrite = id_regwrite & ~id_is_long;
            ex_next_s.is_load  = id_is_load;
        end else begin
            ex_next_s = '{valid: 1'b0, rd: X0, regwrite: 1'b0, is_load: 1'b0};
        end
    end

    // Destination-tag pipeline EX -> MEM -> WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= '{valid: 1'b0, rd: X0, regwrite: 1'b0, is_load: 1'b0};
            mem_r <= '{valid: 1'b0, rd: X0, regwrite: 1'b0, is_load: 1'b0};
            wb_r  <= '{valid: 1'b0, rd: X0, regwrite: 1'b0, is_load: 1'b0};
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Long-op scoreboard: writeback clear applies before a same-cycle issue set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec_r  <= {NUM_REGS{1'b0}};
            long_busy_r <= 1'b0;
        end else begin
            busy_vec_r <= (busy_vec_r & ~clr_mask_s) | set_mask_s;
            if (long_issue_s) begin
                long_busy_r <= 1'b1;
            end else if (wb_ok_s) begin
                long_busy_r <= 1'b0;
            end else begin
                long_busy_r <= long_busy_r;
            end
        end
    end

    // Saturating latency counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_r <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            if (long_issue_s) begin
                lat_cnt_r <= {CNT_W{1'b0}};
            end else if (long_busy_r && (lat_cnt_r != LAT_MAX)) begin
                lat_cnt_r <= lat_cnt_r + CNT_W'(1);
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if ((long_wb_valid && !wb_ok_s) || lat_hit_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign stall       = stall_s;
    assign stall_cause = {struct_s, waw_s, load_use_s};
    assign fwd_sel     = fwd_sel_s;
    assign long_busy   = long_busy_r;
    assign err         = err_r;

endmodule
